adc_avg_sequencer: RTL and testbench

Conversion sequencer and oversampling averager downstream of the SAR ADC controller. It issues periodic single-cycle start pulses and captures each finished conversion word on the ready strobe. It accumulates 2^OSR_LOG2 results and presents the averaged word on a valid/ready output port toward the digital back end.

---
 rtl/adc_pkg.sv | 21 ++
 rtl/adc_avg_accum.sv | 68 ++++++
 rtl/adc_avg_sequencer.sv | 127 ++++++++++++
 tb/tb_adc_avg_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared types and sizing helpers for the ADC conversion sequencer / averager.
// The ADC_AVG_ROUND_EN build macro is consumed by adc_avg_accum, not here.
package adc_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      START = 2'd2,
      BUSY  = 2'd3
   } seq_state_t;

   // Sum of 2^osr words of res bits fits in res+osr bits.
   function automatic int unsigned acc_width(input int unsigned res, input int unsigned osr);
      return res + osr;
   endfunction

   function automatic int unsigned cnt_width(input int unsigned osr);
      return (osr == 0) ? 1 : osr;
   endfunction

endpackage

// File: rtl/adc_avg_accum.sv
// Oversampling accumulator: sums 2^OSR_LOG2 samples and produces the average.
// Define ADC_AVG_ROUND_EN for round-half-up with saturation; default truncates.
module adc_avg_accum
   import adc_pkg::*;
#(
   parameter int unsigned RESOLUTION = 4,
   parameter int unsigned OSR_LOG2   = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  clr_i,
   input  logic                  add_i,
   input  logic [RESOLUTION-1:0] sample_i,
   output logic                  done_o,
   output logic [RESOLUTION-1:0] avg_o
);

   localparam int unsigned ACC_W = acc_width(RESOLUTION, OSR_LOG2);
   localparam int unsigned CNT_W = cnt_width(OSR_LOG2);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((2 ** OSR_LOG2) - 1);

   logic [ACC_W-1:0] acc_q, acc_d;
   logic [ACC_W-1:0] sum;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      sum    = acc_q + ACC_W'(sample_i);
      done_o = add_i && (cnt_q == CNT_LAST);
      acc_d  = acc_q;
      cnt_d  = cnt_q;
      if (clr_i || done_o) begin
         acc_d = '0;
         cnt_d = '0;
      end else if (add_i) begin
         acc_d = sum;
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         acc_q <= '0;
         cnt_q <= '0;
      end else begin
         acc_q <= acc_d;
         cnt_q <= cnt_d;
      end
   end

   // The average is taken from the sum that already includes the final sample.
`ifdef ADC_AVG_ROUND_EN
   localparam int unsigned HALF = (2 ** OSR_LOG2) / 2;

   logic [ACC_W:0]      rnd;
   logic [RESOLUTION:0] rnd_shift;

   always_comb begin
      rnd       = {1'b0, sum} + (ACC_W+1)'(HALF);
      rnd_shift = (RESOLUTION+1)'(rnd >> OSR_LOG2);
      avg_o     = rnd_shift[RESOLUTION] ? '1 : rnd_shift[RESOLUTION-1:0];
   end
`else
   always_comb begin
      avg_o = RESOLUTION'(sum >> OSR_LOG2);
   end
`endif

endmodule

// File: rtl/adc_avg_sequencer.sv
// Conversion sequencer: periodic start pulses, sample capture, averaged output on valid/ready.
// Build option ADC_AVG_ROUND_EN selects rounded/saturated averaging inside adc_avg_accum.
module adc_avg_sequencer
   import adc_pkg::*;
#(
   parameter int unsigned RESOLUTION = 4,
   parameter int unsigned OSR_LOG2   = 2,
   parameter int unsigned PERIOD_W   = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  en_i,
   input  logic [PERIOD_W-1:0]   period_i,
   output logic                  start_o,
   input  logic                  rdy_i,
   input  logic [RESOLUTION-1:0] dac_i,
   output logic [RESOLUTION-1:0] data_o,
   output logic                  valid_o,
   input  logic                  ready_i,
   output logic                  overrun_o
);

   seq_state_t state_q, state_d;
   logic [PERIOD_W-1:0]   ival_q, ival_d;
   logic                  start_q, start_d;
   logic                  valid_q, valid_d;
   logic [RESOLUTION-1:0] data_q, data_d;
   logic                  overrun_q, overrun_d;

   logic                  acc_clr;
   logic                  acc_add;
   logic                  acc_done;
   logic [RESOLUTION-1:0] acc_avg;
   logic                  xfer;

   adc_avg_accum #(
      .RESOLUTION (RESOLUTION),
      .OSR_LOG2   (OSR_LOG2)
   ) u_accum (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .clr_i    (acc_clr),
      .add_i    (acc_add),
      .sample_i (dac_i),
      .done_o   (acc_done),
      .avg_o    (acc_avg)
   );

   always_comb begin
      state_d = state_q;
      ival_d  = ival_q;
      acc_clr = 1'b0;
      acc_add = 1'b0;
      if (!en_i) begin
         state_d = IDLE;
         acc_clr = 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = WAIT;
               ival_d  = period_i;
            end
            WAIT: begin
               if (ival_q == '0) begin
                  state_d = START;
               end else begin
                  ival_d = ival_q - PERIOD_W'(1);
               end
            end
            START: state_d = BUSY;
            BUSY: begin
               if (rdy_i) begin
                  acc_add = 1'b1;
                  state_d = WAIT;
                  ival_d  = period_i;
               end
            end
            default: state_d = IDLE;
         endcase
      end
      // Registered pulse: high exactly during the START cycle.
      start_d = (state_d == START);
   end

   always_comb begin
      xfer      = valid_q && ready_i;
      valid_d   = valid_q;
      data_d    = data_q;
      overrun_d = overrun_q;
      if (acc_done) begin
         valid_d = 1'b1;
         data_d  = acc_avg;
         if (valid_q && !ready_i) begin
            overrun_d = 1'b1;
         end
      end else if (xfer) begin
         valid_d = 1'b0;
      end
      if (!en_i) begin
         overrun_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         ival_q    <= '0;
         start_q   <= 1'b0;
         valid_q   <= 1'b0;
         data_q    <= '0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ival_q    <= ival_d;
         start_q   <= start_d;
         valid_q   <= valid_d;
         data_q    <= data_d;
         overrun_q <= overrun_d;
      end
   end

   assign start_o   = start_q;
   assign valid_o   = valid_q;
   assign data_o    = data_q;
   assign overrun_o = overrun_q;

endmodule

// File: tb/tb_adc_avg_sequencer.sv
// Self-checking bench for adc_avg_sequencer (RESOLUTION=4, OSR_LOG2=2).
// Expected averages follow ADC_AVG_ROUND_EN when the macro is defined.
module tb_adc_avg_sequencer;

   localparam int unsigned RES   = 4;
   localparam int unsigned OSR   = 2;
   localparam int unsigned PW    = 16;
   localparam int          NSAMP = 4;

   logic           clk_i    = 1'b0;
   logic           rst_ni   = 1'b0;
   logic           en_i     = 1'b0;
   logic [PW-1:0]  period_i = '0;
   logic           start_o;
   logic           rdy_i    = 1'b0;
   logic [RES-1:0] dac_i    = '0;
   logic [RES-1:0] data_o;
   logic           valid_o;
   logic           ready_i  = 1'b0;
   logic           overrun_o;

   adc_avg_sequencer #(
      .RESOLUTION (RES),
      .OSR_LOG2   (OSR),
      .PERIOD_W   (PW)
   ) dut (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .en_i      (en_i),
      .period_i  (period_i),
      .start_o   (start_o),
      .rdy_i     (rdy_i),
      .dac_i     (dac_i),
      .data_o    (data_o),
      .valid_o   (valid_o),
      .ready_i   (ready_i),
      .overrun_o (overrun_o)
   );

   always #5 clk_i = ~clk_i;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Reference model: time-based view of the sequencer and the output port.
   int m_next_start = -1;
   bit m_armed      = 1'b0;
   int m_cnt        = 0;
   int m_sum        = 0;
   bit m_valid      = 1'b0;
   int m_data       = 0;
   bit m_ovr        = 1'b0;

   // Converter model and logs.
   int lat          = 1;
   int cc           = 0;
   int last_rdy_cyc = -1;
   int samp_q[$];
   int start_log[$];

   typedef struct {
      int s0, s1, s2, s3;
      int period;
      int lat;
      int exp_t;
      int exp_r;
   } vec_t;

   vec_t vecs[7];

   function automatic int exp_avg(input int s);
      int r;
`ifdef ADC_AVG_ROUND_EN
      r = (s + NSAMP / 2) / NSAMP;
      if (r > 15) r = 15;
`else
      r = s / NSAMP;
`endif
      return r;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_next_start = -1;
      m_armed      = 1'b0;
      m_cnt        = 0;
      m_sum        = 0;
      m_valid      = 1'b0;
      m_data       = 0;
      m_ovr        = 1'b0;
      cc           = 0;
      last_rdy_cyc = -1;
      start_log.delete();
      samp_q.delete();
   endtask

   task automatic model_edge();
      bit load;
      load = 1'b0;
      if (!rst_ni) return;
      if (!en_i) begin
         m_next_start = -1;
         m_armed      = 1'b0;
         m_cnt        = 0;
         m_sum        = 0;
      end else if (m_armed) begin
         if (rdy_i) begin
            m_armed      = 1'b0;
            m_next_start = cyc + int'(period_i) + 2;
            m_sum       += int'(dac_i);
            m_cnt++;
            if (m_cnt == NSAMP) begin
               load  = 1'b1;
               m_cnt = 0;
            end
         end
      end else if (cyc == m_next_start) begin
         m_armed      = 1'b1;
         m_next_start = -1;
      end else if (m_next_start < 0) begin
         m_next_start = cyc + int'(period_i) + 2;
      end
      if (load) begin
         if (m_valid && !ready_i) m_ovr = 1'b1;
         m_valid = 1'b1;
         m_data  = exp_avg(m_sum);
         m_sum   = 0;
      end else if (m_valid && ready_i) begin
         m_valid = 1'b0;
      end
      if (!en_i) m_ovr = 1'b0;
   endtask

   task automatic step();
      @(posedge clk_i);
      model_edge();
      cyc++;
      @(negedge clk_i);
      chk("start_o", int'(start_o), int'(cyc == m_next_start));
      chk("valid_o", int'(valid_o), int'(m_valid));
      chk("data_o", int'(data_o), m_data);
      chk("overrun_o", int'(overrun_o), int'(m_ovr));
      if (start_o) start_log.push_back(cyc);
      rdy_i = 1'b0;
      if (cc > 0) begin
         cc--;
         if (cc == 0) begin
            rdy_i        = 1'b1;
            dac_i        = (samp_q.size() > 0) ? RES'(samp_q.pop_front()) : RES'($urandom_range(0, 15));
            last_rdy_cyc = cyc;
         end
      end
      if (start_o) cc = lat;
   endtask

   task automatic reset_dut();
      en_i    = 1'b0;
      rdy_i   = 1'b0;
      ready_i = 1'b0;
      rst_ni  = 1'b0;
      model_reset();
      step();
      step();
      rst_ni = 1'b1;
   endtask

   task automatic wait_valid(input int max_cyc);
      for (int i = 0; i < max_cyc && !valid_o; i++) step();
      chk("wait_valid", int'(valid_o), 1);
   endtask

   initial begin
      int en_cyc;
      int n;
      vec_t v;

      vecs[0] = '{5, 6, 7, 8, 3, 2, 6, 7};
      vecs[1] = '{15, 15, 15, 15, 0, 1, 15, 15};
      vecs[2] = '{1, 1, 1, 1, 2, 3, 1, 1};
      vecs[3] = '{0, 0, 0, 1, 1, 1, 0, 0};
      vecs[4] = '{1, 1, 0, 0, 4, 2, 0, 1};
      vecs[5] = '{3, 2, 2, 2, 0, 4, 2, 2};
      vecs[6] = '{14, 15, 15, 15, 5, 1, 14, 15};

      // Table-driven single averages.
      for (int k = 0; k < 7; k++) begin
         v = vecs[k];
         reset_dut();
         chk("reset_valid", int'(valid_o), 0);
         period_i = PW'(v.period);
         lat      = v.lat;
         samp_q   = '{v.s0, v.s1, v.s2, v.s3};
         en_i     = 1'b1;
         en_cyc   = cyc;
         wait_valid(400);
         chk("valid_latency", cyc - last_rdy_cyc, 1);
`ifdef ADC_AVG_ROUND_EN
         chk("avg", int'(data_o), v.exp_r);
`else
         chk("avg", int'(data_o), v.exp_t);
`endif
         if (start_log.size() < 2) begin
            chk("start_count", start_log.size(), 4);
         end else begin
            chk("first_start", start_log[0] - en_cyc, v.period + 2);
            chk("start_gap", start_log[1] - start_log[0], v.lat + v.period + 2);
         end
         ready_i = 1'b1;
         step();
         chk("valid_clear", int'(valid_o), 0);
         ready_i = 1'b0;
      end

      // Overrun across two unaccepted averages.
      reset_dut();
      period_i = PW'(1);
      lat      = 2;
      samp_q   = '{2, 2, 2, 2, 9, 9, 9, 9};
      en_i     = 1'b1;
      for (int i = 0; i < 500 && !overrun_o; i++) step();
      chk("ovr_set", int'(overrun_o), 1);
      chk("ovr_data", int'(data_o), 9);
      chk("ovr_valid", int'(valid_o), 1);
      ready_i = 1'b1;
      step();
      ready_i = 1'b0;
      chk("ovr_accept_valid", int'(valid_o), 0);
      chk("ovr_sticky", int'(overrun_o), 1);
      en_i = 1'b0;
      step();
      chk("ovr_clear_en", int'(overrun_o), 0);

      // Partial sum discarded when enable drops.
      reset_dut();
      period_i = PW'(2);
      lat      = 2;
      samp_q   = '{7, 7, 1, 1, 1, 1};
      ready_i  = 1'b1;
      en_i     = 1'b1;
      for (int i = 0; i < 200 && samp_q.size() > 4; i++) step();
      step();
      en_i = 1'b0;
      repeat (3) step();
      en_i = 1'b1;
      wait_valid(400);
      chk("partial_discard", int'(data_o), 1);

      // Spurious strobes in IDLE and WAIT.
      reset_dut();
      period_i = PW'(3);
      lat      = 2;
      ready_i  = 1'b1;
      rdy_i    = 1'b1;
      dac_i    = 4'd15;
      step();
      en_i = 1'b1;
      step();
      rdy_i = 1'b1;
      dac_i = 4'd15;
      step();
      samp_q = '{3, 3, 3, 3};
      wait_valid(400);
      chk("spurious_ignored", int'(data_o), 3);

      // Asynchronous reset while BUSY with a pending result.
      reset_dut();
      period_i = PW'(2);
      lat      = 6;
      samp_q   = '{4, 4, 4, 4};
      en_i     = 1'b1;
      wait_valid(400);
      n = start_log.size();
      for (int i = 0; i < 100 && start_log.size() == n; i++) step();
      step();
      chk("pre_reset_valid", int'(valid_o), 1);
      #2 rst_ni = 1'b0;
      #1;
      chk("rst_start", int'(start_o), 0);
      chk("rst_valid", int'(valid_o), 0);
      chk("rst_data", int'(data_o), 0);
      chk("rst_ovr", int'(overrun_o), 0);
      model_reset();
      step();
      rst_ni = 1'b1;
      en_cyc = cyc;
      for (int i = 0; i < 100 && start_log.size() == 0; i++) step();
      if (start_log.size() == 0) chk("restart_seen", 0, 1);
      else chk("restart_latency", start_log[0] - en_cyc, 4);

      // Randomised segments against the reference model.
      for (int seg = 0; seg < 6; seg++) begin
         int rdy_pct;
         reset_dut();
         lat     = int'($urandom_range(1, 6));
         rdy_pct = (seg % 2 == 0) ? 20 : 80;
         for (int i = 0; i < 800; i++) begin
            period_i = PW'($urandom_range(0, 5));
            ready_i  = ($urandom_range(0, 99) < rdy_pct);
            en_i     = ($urandom_range(0, 99) >= 2);
            if (!rdy_i && $urandom_range(0, 99) < 3) begin
               rdy_i = 1'b1;
               dac_i = RES'($urandom_range(0, 15));
            end
            step();
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
